// File: rtl/crc8_frame_sched.sv
// crc8_frame_sched: folds 32-bit words into a CRC-8, one byte per cycle, MSB byte first, and presents
// the frame CRC on a result handshake. Define CRC_CHECK_EN to add the expected-CRC compare (in_crc/res_ok).
//
// state | meaning
// IDLE  | ready for the next word of the current frame, or the first word of a new one
// BYTE  | folding the latched word into the CRC, one byte per cycle
// DONE  | frame CRC presented, held until res_ready
module crc8_frame_sched #(
  parameter logic [7:0] POLY  = 8'h31,
  parameter logic [7:0] INIT  = 8'h00,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
`ifdef CRC_CHECK_EN
  input  logic [7:0]       in_crc,
  output logic             res_ok,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_crc,
  output logic [CNT_W-1:0] res_words,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BYTE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [7:0]       crc, crc_nxt;
  logic [1:0]       byte_cnt, byte_cnt_nxt;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [31:0]      data_q, data_nxt;
  logic             last_q, last_nxt;
  logic [7:0]       cur_byte;

  // Bitwise CRC-8 step: xor the byte in, then eight MSB-first shift/reduce rounds.
  function automatic logic [7:0] crc_step(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    case (byte_cnt)
      2'd0:    cur_byte = data_q[31:24];
      2'd1:    cur_byte = data_q[23:16];
      2'd2:    cur_byte = data_q[15:8];
      default: cur_byte = data_q[7:0];
    endcase
  end

`ifdef CRC_CHECK_EN
  logic [7:0] exp_q, exp_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      crc      <= INIT;
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
`ifdef CRC_CHECK_EN
      exp_q    <= 8'h00;
`endif
    end else begin
      state    <= state_nxt;
      crc      <= crc_nxt;
      byte_cnt <= byte_cnt_nxt;
      word_cnt <= word_cnt_nxt;
      data_q   <= data_nxt;
      last_q   <= last_nxt;
`ifdef CRC_CHECK_EN
      exp_q    <= exp_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    crc_nxt      = crc;
    byte_cnt_nxt = byte_cnt;
    word_cnt_nxt = word_cnt;
    data_nxt     = data_q;
    last_nxt     = last_q;
`ifdef CRC_CHECK_EN
    exp_nxt      = exp_q;
`endif
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    res_crc      = 8'h00;
    res_words    = '0;

    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_nxt     = in_data;
          last_nxt     = in_last;
          byte_cnt_nxt = 2'd0;
          word_cnt_nxt = (&word_cnt) ? word_cnt : word_cnt + CNT_ONE;
`ifdef CRC_CHECK_EN
          if (in_last) exp_nxt = in_crc;
`endif
          state_nxt    = S_BYTE;
        end
      end
      S_BYTE: begin
        crc_nxt      = crc_step(crc, cur_byte);
        byte_cnt_nxt = byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          state_nxt = last_q ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        res_crc   = crc;
        res_words = word_cnt;
        // Next frame restarts from INIT only once the consumer has taken this result.
        if (res_ready) begin
          crc_nxt      = INIT;
          word_cnt_nxt = '0;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

`ifdef CRC_CHECK_EN
  assign res_ok = (state == S_DONE) && (crc == exp_q);
`endif

endmodule

// File: tb/tb_crc8_frame_sched.sv
// Directed bench for crc8_frame_sched: hand-computed CRC-8 (poly 0x31) vectors, handshake timing,
// hold, reset and counter saturation (second instance with a 2-bit word counter).
module tb_crc8_frame_sched;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        res_ready;
  logic [7:0]  in_crc;

  logic        in_ready, res_valid, busy;
  logic [7:0]  res_crc;
  logic [15:0] res_words;
  logic        res_ok;

  logic        in_ready_s, res_valid_s, busy_s;
  logic [7:0]  res_crc_s;
  logic [1:0]  res_words_s;
  logic        res_ok_s;

  int n_cmp = 0;
  int n_err = 0;

  crc8_frame_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
`ifdef CRC_CHECK_EN
    .in_crc(in_crc), .res_ok(res_ok),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc),
    .res_words(res_words), .busy(busy)
  );

  crc8_frame_sched #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last),
`ifdef CRC_CHECK_EN
    .in_crc(in_crc), .res_ok(res_ok_s),
`endif
    .res_valid(res_valid_s), .res_ready(res_ready), .res_crc(res_crc_s),
    .res_words(res_words_s), .busy(busy_s)
  );

`ifndef CRC_CHECK_EN
  assign res_ok   = 1'b0;
  assign res_ok_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n >= 50) begin
      n_err++;
      $display("FAIL send_timeout: in_ready got %b want 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc >= 40) begin
      n_err++;
      $display("FAIL result_timeout: res_valid got %b want 1", res_valid);
    end
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0; in_crc = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (res_crc !== 8'h00) begin n_err++; $display("FAIL rst_res_crc got %h want 00", res_crc); end
    n_cmp++; if (res_words !== 16'h0) begin n_err++; $display("FAIL rst_res_words got %h want 0", res_words); end
    n_cmp++; if (res_ok !== 1'b0) begin n_err++; $display("FAIL rst_res_ok got %b want 0", res_ok); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    logic [31:0] vec_d [4];
    logic [7:0]  vec_c [4];
    int cyc;
    vec_d[0] = 32'h0000_0001; vec_c[0] = 8'h31;
    vec_d[1] = 32'h0000_0080; vec_c[1] = 8'h7A;
    vec_d[2] = 32'h0000_0000; vec_c[2] = 8'h00;
    vec_d[3] = 32'h0000_0100; vec_c[3] = 8'hF4;
    for (int i = 0; i < 4; i++) begin
      send_word(vec_d[i], 1'b1);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL single_in_ready[%0d] got %b want 0", i, in_ready); end
      wait_result(cyc);
      n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL single_latency[%0d] got %0d want 4", i, cyc); end
      n_cmp++; if (res_crc !== vec_c[i]) begin n_err++; $display("FAIL single_crc[%0d] got %h want %h", i, res_crc, vec_c[i]); end
      n_cmp++; if (res_words !== 16'd1) begin n_err++; $display("FAIL single_words[%0d] got %0d want 1", i, res_words); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy[%0d] got %b want 1", i, busy); end
      take_result();
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_release[%0d] got %b want 0", i, res_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle[%0d] got %b want 0", i, busy); end
    end
  endtask

  task automatic test_back_to_back();
    int lows;
    int cyc;
    in_valid = 1'b1; in_data = 32'h0; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h0000_0001; in_last = 1'b1;
    lows = 0;
    while (in_ready === 1'b0 && lows < 10) begin
      lows++;
      @(posedge clk); #1;
    end
    n_cmp++; if (lows !== 4) begin n_err++; $display("FAIL b2b_ready_low got %0d want 4", lows); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept got %b want 0", in_ready); end
    wait_result(cyc);
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL b2b_latency got %0d want 4", cyc); end
    n_cmp++; if (res_crc !== 8'h31) begin n_err++; $display("FAIL b2b_crc got %h want 31", res_crc); end
    n_cmp++; if (res_words !== 16'd2) begin n_err++; $display("FAIL b2b_words got %0d want 2", res_words); end
    take_result();
  endtask

  task automatic test_idle_gap();
    int cyc;
    send_word(32'h0000_0001, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_busy got %b want 0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL gap_res_valid got %b want 0", res_valid); end
    send_word(32'h0000_0000, 1'b1);
    wait_result(cyc);
    n_cmp++; if (res_crc !== 8'hD3) begin n_err++; $display("FAIL gap_crc got %h want d3", res_crc); end
    n_cmp++; if (res_words !== 16'd2) begin n_err++; $display("FAIL gap_words got %0d want 2", res_words); end
    take_result();
  endtask

  task automatic test_hold();
    int cyc;
    send_word(32'h0000_0080, 1'b1);
    wait_result(cyc);
    in_valid = 1'b1; in_data = 32'h0000_0001; in_last = 1'b1; in_crc = 8'h31;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got %b want 1", i, res_valid); end
      n_cmp++; if (res_crc !== 8'h7A) begin n_err++; $display("FAIL hold_crc[%0d] got %h want 7a", i, res_crc); end
      n_cmp++; if (res_words !== 16'd1) begin n_err++; $display("FAIL hold_words[%0d] got %0d want 1", i, res_words); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); end
    end
    take_result();
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got %b want 0", res_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_idle_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_next_accept got %b want 1", busy); end
    wait_result(cyc);
    n_cmp++; if (res_crc !== 8'h31) begin n_err++; $display("FAIL hold_next_crc got %h want 31", res_crc); end
    n_cmp++; if (res_words !== 16'd1) begin n_err++; $display("FAIL hold_next_words got %0d want 1", res_words); end
    take_result();
  endtask

  task automatic test_early_ready();
    int cyc;
    res_ready = 1'b1;
    send_word(32'h0001_0000, 1'b1);
    wait_result(cyc);
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL early_latency got %0d want 4", cyc); end
    n_cmp++; if (res_crc !== 8'h46) begin n_err++; $display("FAIL early_crc got %h want 46", res_crc); end
    @(posedge clk); #1;
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL early_consumed got %b want 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < 4; i++) send_word(32'h0, 1'b0);
    send_word(32'h0000_0001, 1'b1);
    wait_result(cyc);
    n_cmp++; if (res_words !== 16'd5) begin n_err++; $display("FAIL sat_words_main got %0d want 5", res_words); end
    n_cmp++; if (res_words_s !== 2'd3) begin n_err++; $display("FAIL sat_words_small got %0d want 3", res_words_s); end
    n_cmp++; if (res_crc_s !== 8'h31) begin n_err++; $display("FAIL sat_crc_small got %h want 31", res_crc_s); end
    n_cmp++; if (res_crc !== 8'h31) begin n_err++; $display("FAIL sat_crc_main got %h want 31", res_crc); end
    take_result();
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h0000_0100, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rmid_res_valid got %b want 0", res_valid); end
    n_cmp++; if (res_words !== 16'd0) begin n_err++; $display("FAIL rmid_res_words got %0d want 0", res_words); end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_word(32'h0000_0001, 1'b1);
    wait_result(cyc);
    n_cmp++; if (res_crc !== 8'h31) begin n_err++; $display("FAIL rmid_crc got %h want 31", res_crc); end
    n_cmp++; if (res_words !== 16'd1) begin n_err++; $display("FAIL rmid_words got %0d want 1", res_words); end
    take_result();
  endtask

`ifdef CRC_CHECK_EN
  task automatic test_crc_check();
    int cyc;
    in_crc = 8'h31;
    send_word(32'h0000_0001, 1'b1);
    in_crc = 8'h00;
    wait_result(cyc);
    n_cmp++; if (res_ok !== 1'b1) begin n_err++; $display("FAIL chk_ok got %b want 1", res_ok); end
    take_result();
    in_crc = 8'h30;
    send_word(32'h0000_0001, 1'b1);
    in_crc = 8'h31;
    wait_result(cyc);
    n_cmp++; if (res_ok !== 1'b0) begin n_err++; $display("FAIL chk_bad got %b want 0", res_ok); end
    take_result();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_idle_gap();
    test_hold();
    test_early_ready();
    test_saturation();
    test_reset_mid();
`ifdef CRC_CHECK_EN
    test_crc_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
